if_id_buf: RTL and testbench
============================

Name: if_id_buf

Overview:
- Parametrised IF/ID pipeline register with an integrated instruction buffer.
- Sits between the fetch stage and the decode stage of the 5-stage MIPS pipeline.
- Instructions that arrive while decode is stalled are queued in a small FIFO instead of being lost.
- Adds a valid bit, an explicit flush, and configurable widths, depth and stall-vector position.

Parameters:
- PC_W, 32: PC width in bits.
- INST_W, 32: instruction width in bits.
- STALL_W, 6: width of the global stall vector.
- STAGE, 1: index of this register's stall bit. STAGE+1 is the downstream bit. Legal range 0..STALL_W-2.
- DEPTH, 2: number of buffer entries. Must be at least 1.
- NOP_INST, 32'h0: instruction value driven while holding a bubble.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- stall, input, STALL_W: global pipeline stall vector.
- flush, input, 1: discards all buffered and output contents (exception or eret).
- if_valid, input, 1: the fetch word on if_pc/if_inst is valid this cycle.
- if_pc, input, PC_W: fetched PC.
- if_inst, input, INST_W: fetched instruction.
- if_ready, output, 1: buffer can accept the fetch word this cycle (combinational).
- id_valid, output, 1: decode-stage word is valid.
- id_pc, output, PC_W: decode-stage PC.
- id_inst, output, INST_W: decode-stage instruction.
- buf_count, output, $clog2(DEPTH+1): current FIFO occupancy (debug).

Behaviour:
- Clock and reset: all state updates on posedge clk. Reset is rst, synchronous, active-high; clock is clk.
- Reset values: id_valid=0, id_pc=0, id_inst=NOP_INST, buf_count=0, FIFO pointers=0.
- Local signals:
  - adv = !stall[STAGE]
  - bubble = stall[STAGE] && !stall[STAGE+1]
  - hold = stall[STAGE] && stall[STAGE+1]
  - push = if_valid && if_ready
- if_ready = (buf_count < DEPTH) || adv. When full, a push is only accepted in a cycle where a pop frees an entry.
- Priority order, highest first: rst, flush, adv, bubble, hold.
- flush:
  - Output becomes a bubble (id_valid=0, id_pc=0, id_inst=NOP_INST).
  - FIFO is emptied, count=0.
  - The incoming fetch word is dropped, even if if_valid=1.
- adv:
  - If the FIFO is non-empty: pop the head into the output (id_valid=1).
  - If the FIFO is non-empty and push: write the incoming word to the tail in the same cycle; count is unchanged.
  - If the FIFO is empty and if_valid: load the incoming word directly into the output. This is bypass with 1-cycle latency; the FIFO is untouched.
  - If the FIFO is empty and !if_valid: output becomes a bubble.
- bubble:
  - Output becomes a bubble so decode does not re-issue its instruction.
  - If push: enqueue the incoming word.
- hold:
  - Output registers keep their value.
  - If push: enqueue the incoming word.
- Ordering: words leave strictly in fetch order. The FIFO head is always older than the bypass path, so bypass is used only when the FIFO is empty.
- Pointers: wrap modulo DEPTH. Count stays within 0..DEPTH. An overflow can only arise from a fetch word offered while if_ready=0; that word is ignored and state is unchanged.
- Latency: minimum 1 cycle from fetch to id_*. Worst case DEPTH+1 advancing cycles.
- Reset mid-operation: buffered words are discarded, with no partial-state dependence.

Decomposition:
- Shared package (pipe_defs): NOP_INST default, the STALL_IF/STALL_ID/... index constants, and a pc_inst_t packed struct {pc, inst}.
- One sub-module, pipe_fifo:
  - Synchronous FIFO, parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout (first-word visible), count, full, empty.
  - Simultaneous push and pop is legal when full.
- if_id_buf instantiates pipe_fifo with WIDTH=PC_W+INST_W and adds the output register and the priority logic.

Test Plan:
1. Reset, then feed pc 0x00,0x04,0x08 with if_valid=1 and stall=0. id_pc follows 1 cycle later (0x00,0x04,0x08), id_valid=1, buf_count=0 throughout.
2. stall=6'b000011 for 2 cycles while 0x10,0x14 arrive (bubble case). id_valid=0, id_inst=NOP_INST, buf_count reaches 2, if_ready=0. On release, id_pc shows 0x10 then 0x14, then the live word.
3. stall=6'b000111 (hold) while id_pc=0x20 and 0x24 arrives. id_pc stays 0x20, id_valid stays 1, buf_count=1. After release the next id_pc is 0x24.
4. FIFO full (DEPTH=2) with adv=1 and if_valid=1 at 0x30. The head pops to id_pc, 0x30 enqueues, and buf_count stays 2.
5. flush=1 with buf_count=2 and if_valid=1. The next cycle has id_valid=0, buf_count=0, and the 0x40 fetch word is dropped.
6. rst asserted with buf_count=2 and id_valid=1. The next cycle has all outputs at their reset values, and the first post-reset fetch appears after 1 cycle.

Source files
------------

// File: rtl/if_id_buf_pkg.sv
// rtl/if_id_buf_pkg.sv - shared pipeline definitions for the IF/ID buffer
package pipe_defs;

    // Instruction driven on the decode side while a bubble is held
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;

    // Bit positions of each stage in the global stall vector
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } pc_inst_t;

endpackage

// File: rtl/pipe_fifo.sv
// rtl/pipe_fifo.sv - synchronous FIFO with first-word-visible output
module pipe_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push then
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_id_buf.sv
// rtl/if_id_buf.sv - IF/ID pipeline register with fetch instruction buffer
module if_id_buf
    import pipe_defs::*;
#(
    parameter int              PC_W     = 32,
    parameter int              INST_W   = 32,
    parameter int              STALL_W  = 6,
    parameter int              STAGE    = STALL_IF,
    parameter int              DEPTH    = 2,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(DEF_NOP_INST)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [STALL_W-1:0]         stall,
    input  logic                       flush,
    input  logic                       if_valid,
    input  logic [PC_W-1:0]            if_pc,
    input  logic [INST_W-1:0]          if_inst,
    output logic                       if_ready,
    output logic                       id_valid,
    output logic [PC_W-1:0]            id_pc,
    output logic [INST_W-1:0]          id_inst,
    output logic [$clog2(DEPTH+1)-1:0] buf_count
);

    localparam int WIDTH = PC_W + INST_W;

    logic             adv;
    logic             bubble;
    logic             push;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             unused_stall;

    assign adv    = !stall[STAGE];
    assign bubble = stall[STAGE] && !stall[STAGE+1];

    // Only two bits of the stall vector matter to this stage
    assign unused_stall = ^stall;

    assign if_ready = !fifo_full || adv;
    assign push     = if_valid && if_ready;

    // The FIFO head is older than the live word, so bypass only when empty
    assign fifo_pop  = !flush && adv && !fifo_empty;
    assign fifo_push = !flush && push && (!adv || !fifo_empty);

    pipe_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst || flush),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  ({if_pc, if_inst}),
        .dout (fifo_dout),
        .count(buf_count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Decode-side register: flush, then advance, then bubble, else hold
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_inst  <= NOP_INST;
        end else if (adv) begin
            if (!fifo_empty) begin
                id_valid <= 1'b1;
                id_pc    <= fifo_dout[WIDTH-1:INST_W];
                id_inst  <= fifo_dout[INST_W-1:0];
            end else if (if_valid) begin
                id_valid <= 1'b1;
                id_pc    <= if_pc;
                id_inst  <= if_inst;
            end else begin
                id_valid <= 1'b0;
                id_pc    <= '0;
                id_inst  <= NOP_INST;
            end
        end else if (bubble) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_inst  <= NOP_INST;
        end
    end

endmodule

// File: tb/tb_if_id_buf.sv
// tb/tb_if_id_buf.sv - directed self-checking bench for if_id_buf
module tb_if_id_buf;

    localparam logic [31:0] NOP = 32'hDEAD_0000;
    localparam logic [5:0]  S_RUN    = 6'b000000;
    localparam logic [5:0]  S_BUBBLE = 6'b000011;
    localparam logic [5:0]  S_HOLD   = 6'b000111;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [1:0]  buf_count;

    int total = 0;
    int bad   = 0;

    if_id_buf #(
        .PC_W    (32),
        .INST_W  (32),
        .STALL_W (6),
        .STAGE   (1),
        .DEPTH   (2),
        .NOP_INST(NOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .flush    (flush),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'hA500_0000 | pc;
    endfunction

    task automatic fetch(input logic v, input logic [31:0] pc);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst_of(pc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic [31:0] pc, input logic [1:0] cnt);
        chk({tag, ".valid"}, 64'(id_valid), 64'd1);
        chk({tag, ".pc"}, 64'(id_pc), 64'(pc));
        chk({tag, ".inst"}, 64'(id_inst), 64'(inst_of(pc)));
        chk({tag, ".cnt"}, 64'(buf_count), 64'(cnt));
    endtask

    task automatic chk_bub(input string tag, input logic [1:0] cnt);
        chk({tag, ".valid"}, 64'(id_valid), 64'd0);
        chk({tag, ".pc"}, 64'(id_pc), 64'd0);
        chk({tag, ".inst"}, 64'(id_inst), 64'(NOP));
        chk({tag, ".cnt"}, 64'(buf_count), 64'(cnt));
    endtask

    initial begin
        rst = 1'b1; stall = S_RUN; flush = 1'b0;
        fetch(1'b0, 32'h0);
        step();
        step();
        rst = 1'b0;
        chk_bub("reset", 2'd0);
        chk("reset.ready", 64'(if_ready), 64'd1);

        // 1: straight-through bypass
        fetch(1'b1, 32'h00); step(); chk_word("t1a", 32'h00, 2'd0);
        fetch(1'b1, 32'h04); step(); chk_word("t1b", 32'h04, 2'd0);
        fetch(1'b1, 32'h08); step(); chk_word("t1c", 32'h08, 2'd0);

        // 2: bubble stall queues words, then drains in order
        stall = S_BUBBLE;
        fetch(1'b1, 32'h10); #1 chk("t2.ready0", 64'(if_ready), 64'd1);
        step(); chk_bub("t2a", 2'd1);
        fetch(1'b1, 32'h14); step(); chk_bub("t2b", 2'd2);
        fetch(1'b1, 32'h18); #1 chk("t2.ready_full", 64'(if_ready), 64'd0);
        stall = S_RUN; fetch(1'b0, 32'h0);
        step(); chk_word("t2c", 32'h10, 2'd1);
        step(); chk_word("t2d", 32'h14, 2'd0);
        fetch(1'b1, 32'h18); step(); chk_word("t2e", 32'h18, 2'd0);

        // 3: hold keeps output and enqueues
        fetch(1'b1, 32'h20); step(); chk_word("t3a", 32'h20, 2'd0);
        stall = S_HOLD; fetch(1'b1, 32'h24);
        step(); chk_word("t3b", 32'h20, 2'd1);
        stall = S_RUN; fetch(1'b0, 32'h0);
        step(); chk_word("t3c", 32'h24, 2'd0);

        // 4: full FIFO with advance pops and pushes together
        stall = S_BUBBLE;
        fetch(1'b1, 32'h28); step();
        fetch(1'b1, 32'h2c); step(); chk_bub("t4a", 2'd2);
        stall = S_RUN; fetch(1'b1, 32'h30);
        #1 chk("t4.ready", 64'(if_ready), 64'd1);
        step(); chk_word("t4b", 32'h28, 2'd2);
        fetch(1'b0, 32'h0);
        step(); chk_word("t4c", 32'h2c, 2'd1);
        step(); chk_word("t4d", 32'h30, 2'd0);
        step(); chk_bub("t4e", 2'd0);

        // 5: overflow offer ignored, then flush drops everything
        stall = S_BUBBLE;
        fetch(1'b1, 32'h34); step();
        fetch(1'b1, 32'h38); step();
        fetch(1'b1, 32'h3c); step(); chk_bub("t5a", 2'd2);
        stall = S_RUN; flush = 1'b1; fetch(1'b1, 32'h40);
        step(); chk_bub("t5b", 2'd0);
        flush = 1'b0; fetch(1'b0, 32'h0);
        step(); chk_bub("t5c", 2'd0);

        // 6: reset mid-operation
        fetch(1'b1, 32'h50); step();
        stall = S_HOLD;
        fetch(1'b1, 32'h54); step();
        fetch(1'b1, 32'h58); step(); chk_word("t6a", 32'h50, 2'd2);
        rst = 1'b1; stall = S_RUN; fetch(1'b0, 32'h0);
        step(); chk_bub("t6b", 2'd0);
        rst = 1'b0; fetch(1'b1, 32'h60);
        step(); chk_word("t6c", 32'h60, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
